// File: rtl/bt_uart_frame_rx.sv
// 8N1 UART receiver that pairs bytes into 16-bit command words, high byte first.
// data_valid 1 clk after the second byte's mid-stop sample; no backpressure, the consumer must take every word.
module bt_uart_frame_rx #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        sync_lost
);

    localparam int CPB    = CLK_HZ / BAUD;
    localparam int HALF   = CPB / 2;
    localparam int TO_CYC = TIMEOUT_BITS * CPB;
    localparam int CNT_W  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int TO_W   = $clog2(TO_CYC + 1);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CPB_M1  = CNT_W'(CPB - 1);
    localparam logic [TO_W-1:0]  TO_M1   = TO_W'(TO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    typedef enum logic {
        PTR_HIGH,
        PTR_LOW
    } ptr_t;

    logic              rx_meta_q, rx_meta_d;
    logic              rxs_q, rxs_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    ptr_t              ptr_q, ptr_d;
    logic [7:0]        high_q, high_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [15:0]       data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              sync_lost_q, sync_lost_d;
    logic              good_byte;
    logic              bad_byte;

    assign rx_meta_d = rx;
    assign rxs_d     = rx_meta_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ptr_q        <= PTR_HIGH;
            high_q       <= '0;
            to_cnt_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            sync_lost_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rxs_q        <= rxs_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            high_q       <= high_d;
            to_cnt_q     <= to_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            sync_lost_q  <= sync_lost_d;
        end
    end

    // Bit-level receive FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        good_byte   = 1'b0;
        bad_byte    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        good_byte = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        bad_byte    = 1'b1;
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Word assembly; the timeout check ignores rxs so it wins over a coincident start bit
    always_comb begin
        ptr_d        = ptr_q;
        high_d       = high_q;
        to_cnt_d     = to_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        sync_lost_d  = 1'b0;
        if (ptr_q == PTR_LOW && state_q == S_IDLE) begin
            if (to_cnt_q == TO_M1) begin
                sync_lost_d = 1'b1;
                ptr_d       = PTR_HIGH;
                to_cnt_d    = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
        if (good_byte) begin
            to_cnt_d = '0;
            if (ptr_q == PTR_HIGH) begin
                high_d = shift_q;
                ptr_d  = PTR_LOW;
            end else begin
                data_out_d   = {high_q, shift_q};
                data_valid_d = 1'b1;
                ptr_d        = PTR_HIGH;
            end
        end
        if (bad_byte) begin
            ptr_d    = PTR_HIGH;
            to_cnt_d = '0;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign sync_lost  = sync_lost_q;

endmodule
